seq_bigint_alu: RTL and testbench
=================================

SEQ_BIGINT_ALU -- requirements
Module: seq_bigint_alu

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 Parameters (name, default, meaning): CHUNK_W, 64, datapath slice width; NUM_CHUNKS, 8, slices per 512-bit word.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  start  in  1  request operation; sampled only in IDLE
  op  in  2  00 ADD, 01 SUB (a-b), 10 XOR, 11 PASS_A
  src_a  in  3  register-file index of operand A
  src_b  in  3  register-file index of operand B
  dst  in  3  register-file index of result
  operand_a  in  512  register-file read port 1 data
  operand_b  in  512  register-file read port 2 data
  sel_reg_read1  out  3  register-file read select 1
  sel_reg_read2  out  3  register-file read select 2
  sel_reg_write  out  3  register-file write select
  data_in  out  512  write-back data to register file
  reg_write_enable  out  1  one-cycle write strobe
  busy  out  1  high in every non-IDLE state
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle pulse: rejected request
  carry_out  out  1  ADD carry / SUB borrow of last operation
  zero  out  1  last result equal to 0

Function
REQ-004 FSM states SHALL be IDLE, LATCH, EXEC, WRITE.
REQ-005 IDLE: on start=1 with src_a, src_b and dst all < 4, SHALL register src_a, src_b, dst, op onto sel_reg_read1, sel_reg_read2, sel_reg_write and go to LATCH.
REQ-006 IDLE: on start=1 with any index >= 4, SHALL pulse err for one cycle, stay in IDLE, and leave selects and flags unchanged.
REQ-007 LATCH: SHALL capture operand_a and operand_b into internal 512-bit registers, clear carry, set chunk counter to 0, and go to EXEC.
REQ-008 EXEC: each cycle SHALL compute 64-bit slice k (bits 64k+63:64k) into the result register, propagate carry to slice k+1, and go to WRITE after k = 7 (exactly 8 EXEC cycles).
REQ-009 ADD SHALL compute a+b+carry; SUB SHALL compute a+~b+carry with initial carry 1; XOR and PASS_A SHALL ignore carry. Results wrap modulo 2^512.
REQ-010 WRITE: for exactly one cycle, SHALL assert reg_write_enable and done with data_in equal to the full result, then return to IDLE.
REQ-011 Latency: with start sampled in cycle 0, done/reg_write_enable SHALL be high in cycle 10 only; a new start is accepted from cycle 11.
REQ-012 carry_out SHALL update at WRITE: ADD = final carry; SUB = inverted final carry (1 = borrow); XOR/PASS_A = 0. zero SHALL update at WRITE. Both SHALL hold until the next WRITE.
REQ-013 start SHALL be ignored while busy=1, with no err.
REQ-014 data_in SHALL hold the last result outside WRITE; reg_write_enable SHALL be 0 outside WRITE.
REQ-015 src_a = src_b and dst = src_a or src_b SHALL be legal. Operands are captured in LATCH, so the write-back does not corrupt the operation.

Reset
REQ-016 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all outputs, selects, counter, carry and internal registers to 0.
REQ-017 Reset during LATCH, EXEC or WRITE SHALL abort the operation. No reg_write_enable or done SHALL be asserted in the cycle after reset is asserted.

Structure
REQ-018 Package bigint_pkg SHALL hold CHUNK_W, NUM_CHUNKS, the op encodings and the FSM state enum.
REQ-019 Sub-module chunk_adder SHALL provide a combinational 64-bit add with carry-in and carry-out, instantiated once and used for both ADD and SUB.

Verification
REQ-020 ADD: a = 2^512-1, b = 1, src 0/1, dst 2 -> data_in = 0, carry_out = 1, zero = 1, done in cycle 10.
REQ-021 SUB: a = 5, b = 7 -> data_in = 2^512-2, carry_out = 1 (borrow), zero = 0. Also a = 7, b = 5 -> data_in = 2, carry_out = 0.
REQ-022 Carry chain: a = 2^64-1 in slice 0 only, b = 1, ADD -> data_in = 2^64, exercising the slice 0 -> 1 carry.
REQ-023 Illegal index: start with dst = 5 -> err pulses in cycle 1, busy stays 0, reg_write_enable is never asserted.
REQ-024 Start while busy: second start in cycle 4 -> ignored, exactly one done. Back-to-back start in cycle 11 -> accepted, done in cycle 21.
REQ-025 Reset mid-EXEC: rst_n = 0 in cycle 5 -> cycle 6 shows busy = 0, done = 0, reg_write_enable = 0, data_in = 0.

Source files
------------

// File: rtl/bigint_pkg.sv
// Shared constants, operation encodings and FSM states for the sequential
// 512-bit ALU.
package bigint_pkg;

    localparam int CHUNK_W    = 64;
    localparam int NUM_CHUNKS = 8;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_XOR    = 2'b10;
    localparam logic [1:0] OP_PASS_A = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_bigint_alu_chunk_adder.sv
// Combinational slice adder with carry in/out, shared by ADD and SUB.
module chunk_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // One extra bit on the left catches the carry out of the slice.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_bigint_alu.sv
// Sequential 512-bit ALU: reads two register-file entries, processes them
// one 64-bit slice per cycle, and writes the result back in a single strobe.
//
// Request handshake: start/op/src_a/src_b/dst are sampled only while busy=0
// (IDLE). A request whose indices are all < 4 is accepted and busy rises the
// next cycle; any other request is answered by a one-cycle err pulse and no
// state change. While busy=1, start is ignored. Completion is the one-cycle
// done/reg_write_enable pulse, during which data_in carries the result.
module seq_bigint_alu
    import bigint_pkg::*;
#(
    parameter int CHUNK_W    = bigint_pkg::CHUNK_W,
    parameter int NUM_CHUNKS = bigint_pkg::NUM_CHUNKS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    op,
    input  logic [2:0]                    src_a,
    input  logic [2:0]                    src_b,
    input  logic [2:0]                    dst,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] operand_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] operand_b,
    output logic [2:0]                    sel_reg_read1,
    output logic [2:0]                    sel_reg_read2,
    output logic [2:0]                    sel_reg_write,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] data_in,
    output logic                          reg_write_enable,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          carry_out,
    output logic                          zero
);

    localparam int DATA_W = CHUNK_W * NUM_CHUNKS;
    localparam int CNT_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    state_t               state;
    state_t               state_next;
    logic [1:0]           op_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    res_q;
    logic [DATA_W-1:0]    res_next;
    logic [CNT_W-1:0]     cnt_q;
    logic                 carry_q;
    logic                 req_legal;
    logic                 last_chunk;
    int                   base;
    logic [CHUNK_W-1:0]   a_slice;
    logic [CHUNK_W-1:0]   b_slice;
    logic [CHUNK_W-1:0]   b_eff;
    logic [CHUNK_W-1:0]   sum_slice;
    logic [CHUNK_W-1:0]   res_slice;
    logic                 sum_cout;

    // Only register-file entries 0..3 are addressable by this block.
    assign req_legal  = !src_a[2] && !src_b[2] && !dst[2];
    assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

    // Select the current slice and form the partial result for it.
    always_comb begin
        base      = int'(cnt_q) * CHUNK_W;
        a_slice   = a_q[base +: CHUNK_W];
        b_slice   = b_q[base +: CHUNK_W];
        b_eff     = (op_q == OP_SUB) ? ~b_slice : b_slice;
        res_slice = sum_slice;
        case (op_q)
            OP_XOR:    res_slice = a_slice ^ b_slice;
            OP_PASS_A: res_slice = a_slice;
            default:   res_slice = sum_slice;
        endcase
        res_next               = res_q;
        res_next[base +: CHUNK_W] = res_slice;
    end

    chunk_adder #(.W(CHUNK_W)) u_adder (
        .a    (a_slice),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (sum_slice),
        .cout (sum_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic: IDLE -> LATCH -> EXEC x NUM_CHUNKS -> WRITE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start && req_legal) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_EXEC;
            ST_EXEC:  if (last_chunk) state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy             = (state != ST_IDLE);
        done             = (state == ST_WRITE);
        reg_write_enable = (state == ST_WRITE);
    end

    // Datapath registers: request capture, operand latch, slice accumulation
    // and result/flag publication on the final slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_reg_read1 <= '0;
            sel_reg_read2 <= '0;
            sel_reg_write <= '0;
            op_q          <= OP_ADD;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            data_in       <= '0;
            carry_out     <= 1'b0;
            zero          <= 1'b0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (req_legal) begin
                            sel_reg_read1 <= src_a;
                            sel_reg_read2 <= src_b;
                            sel_reg_write <= dst;
                            op_q          <= op;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    a_q     <= operand_a;
                    b_q     <= operand_b;
                    cnt_q   <= '0;
                    // Carry starts clear; SUB seeds it with the +1 of two's complement.
                    carry_q <= (op_q == OP_SUB);
                end
                ST_EXEC: begin
                    res_q <= res_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= sum_cout;
                    if (last_chunk) begin
                        data_in <= res_next;
                        zero    <= (res_next == '0);
                        case (op_q)
                            OP_ADD:  carry_out <= sum_cout;
                            OP_SUB:  carry_out <= ~sum_cout;
                            default: carry_out <= 1'b0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bigint_alu.sv
// Self-checking bench for seq_bigint_alu: a behavioural register file feeds
// the DUT, directed operations push hand-computed results into a scoreboard,
// and a monitor pops and compares them on every completion pulse.
module tb_seq_bigint_alu;

    localparam int W = 512;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [2:0]    src_a, src_b, dst;
    logic [W-1:0]  operand_a, operand_b;
    logic [2:0]    sel_reg_read1, sel_reg_read2, sel_reg_write;
    logic [W-1:0]  data_in;
    logic          reg_write_enable, busy, done, err, carry_out, zero;

    logic [W-1:0]  rf [0:7];
    logic          ld_en;
    logic [2:0]    ld_idx;
    logic [W-1:0]  ld_val;

    logic [W+1:0]  exp_q [$];
    int            cyc_q [$];
    int            cyc;
    int            n_cmp;
    int            n_err;

    logic [W-1:0]  all_ones;
    logic [W-1:0]  low64_ones;
    logic [W-1:0]  pat_a, pat_b, pat_x;

    seq_bigint_alu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .op               (op),
        .src_a            (src_a),
        .src_b            (src_b),
        .dst              (dst),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .sel_reg_read1    (sel_reg_read1),
        .sel_reg_read2    (sel_reg_read2),
        .sel_reg_write    (sel_reg_write),
        .data_in          (data_in),
        .reg_write_enable (reg_write_enable),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .carry_out        (carry_out),
        .zero             (zero)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: DUT write-back has priority over bench preloads.
    assign operand_a = rf[sel_reg_read1];
    assign operand_b = rf[sel_reg_read2];

    always @(posedge clk) begin
        if (reg_write_enable) rf[sel_reg_write] <= data_in;
        else if (ld_en)       rf[ld_idx]        <= ld_val;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        logic [W+1:0] e;
        int           t;
        if (rst_n && (done || reg_write_enable)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=%0b rwe=%0b expected none at cycle %0d",
                         done, reg_write_enable, cyc);
            end else begin
                e = exp_q.pop_front();
                t = cyc_q.pop_front();
                chk("done_and_rwe", W'({done, reg_write_enable}), W'(2'b11));
                chk("data_in", data_in, e[W-1:0]);
                chk("zero", W'(zero), W'(e[W]));
                chk("carry_out", W'(carry_out), W'(e[W+1]));
                chk("done_cycle", W'(cyc), W'(t));
            end
        end
    end

    task automatic load(input logic [2:0] idx, input logic [W-1:0] val);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        @(posedge clk);
        #1;
        ld_en  = 1'b0;
    endtask

    // Presents one request; it is sampled on the next rising edge. The
    // completion is expected 9 edges after that sampling edge (cycle 10).
    task automatic issue(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [W-1:0] ed, input logic ec,
                         input logic ez, input bit push);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        dst   = d;
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back({ec, ez, ed});
            cyc_q.push_back(cyc + 9);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("wait_idle_timeout", W'(k), W'(0));
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [W-1:0] ed, input logic ec,
                       input logic ez);
        issue(o, a, b, d, ed, ec, ez, 1'b1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = 3'd0;
        src_b = 3'd0;
        dst   = 3'd0;
        ld_en = 1'b0;
        ld_idx = 3'd0;
        ld_val = '0;
        for (int i = 0; i < 8; i++) rf[i] = '0;

        all_ones   = '1;
        low64_ones = W'({64{1'b1}});
        pat_a      = {8{64'hF0F0_F0F0_F0F0_F0F0}};
        pat_b      = {8{64'hFF00_FF00_FF00_FF00}};
        pat_x      = {8{64'h0FF0_0FF0_0FF0_0FF0}};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_in", data_in, '0);
        chk("reset_ctrl", W'({busy, done, reg_write_enable, err, carry_out, zero}), W'(6'b0));
        chk("reset_sels", W'({sel_reg_read1, sel_reg_read2, sel_reg_write}), W'(9'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // ADD overflow: (2^512-1) + 1 wraps to 0 with carry.
        load(3'd0, all_ones);
        load(3'd1, W'(1));
        run(2'b00, 3'd0, 3'd1, 3'd2, '0, 1'b1, 1'b1);

        // XOR right after a carrying ADD must clear carry_out.
        load(3'd0, pat_a);
        load(3'd1, pat_b);
        run(2'b10, 3'd0, 3'd1, 3'd3, pat_x, 1'b0, 1'b0);

        // SUB with and without borrow.
        load(3'd0, W'(5));
        load(3'd1, W'(7));
        run(2'b01, 3'd0, 3'd1, 3'd2, {{(W-1){1'b1}}, 1'b0}, 1'b1, 1'b0);
        run(2'b01, 3'd1, 3'd0, 3'd3, W'(2), 1'b0, 1'b0);

        // Carry from slice 0 into slice 1.
        load(3'd0, low64_ones);
        load(3'd1, W'(1));
        run(2'b00, 3'd0, 3'd1, 3'd2, W'(1) << 64, 1'b0, 1'b0);

        // Aliased sources and destination; second op reads the write-back.
        run(2'b00, 3'd1, 3'd1, 3'd1, W'(2), 1'b0, 1'b0);
        run(2'b00, 3'd1, 3'd1, 3'd1, W'(4), 1'b0, 1'b0);

        // PASS_A reading r2, which holds the earlier 2^64 write-back.
        run(2'b11, 3'd2, 3'd3, 3'd2, W'(1) << 64, 1'b0, 1'b0);

        // Illegal destination index: err pulse only, nothing else moves.
        issue(2'b00, 3'd0, 3'd1, 3'd5, '0, 1'b0, 1'b0, 1'b0);
        chk("illegal_err", W'(err), W'(1));
        chk("illegal_busy", W'(busy), W'(0));
        chk("illegal_sels", W'({sel_reg_read1, sel_reg_read2, sel_reg_write}),
            W'({3'd2, 3'd3, 3'd2}));
        chk("illegal_flags", W'({carry_out, zero}), W'(2'b00));
        @(posedge clk);
        #1;
        chk("illegal_err_clear", W'(err), W'(0));
        repeat (12) @(negedge clk);

        // Start while busy is ignored; back-to-back start in cycle 11 accepted.
        // r1 = 4: r3 = 4+4 = 8, then r0 = r3 - r1 = 4 using the fresh write-back.
        issue(2'b00, 3'd1, 3'd1, 3'd3, W'(8), 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b10;
        dst   = 3'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_no_err", W'(err), W'(0));
        chk("busy_start_busy", W'(busy), W'(1));
        repeat (6) @(posedge clk);
        #1;
        issue(2'b01, 3'd3, 3'd1, 3'd0, W'(4), 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Reset during EXEC aborts; the aborted op must never complete.
        issue(2'b00, 3'd0, 3'd1, 3'd2, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ctrl", W'({busy, done, reg_write_enable}), W'(3'b000));
        chk("rst_mid_data_in", data_in, '0);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);

        // Recovery after reset.
        run(2'b11, 3'd1, 3'd0, 3'd2, W'(4), 1'b0, 1'b0);

        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
